id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 167 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// Decode/execute boundary: register file with write-through, operand forwarding,
// load-use stall, early branch resolution and the ID/EX pipeline register.
module id_ex_stage #(
   parameter int NUM_REG        = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int REG_WIDTH      = 32,
   parameter int PC_WIDTH       = 32,
   parameter int NUM_FWD        = 3,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic                              id_valid,
   output logic                              id_ready,
   input  logic [PC_WIDTH-1:0]               id_pc,
   input  logic [REG_ADDR_WIDTH-1:0]         id_rs1,
   input  logic [REG_ADDR_WIDTH-1:0]         id_rs2,
   input  logic [REG_ADDR_WIDTH-1:0]         id_rd,
   input  logic                              id_rd_wr,
   input  logic                              id_is_load,
   input  logic                              id_is_branch,
   input  logic                              id_br_un,
   input  logic [1:0]                        id_br_type,
   input  logic [REG_WIDTH-1:0]              id_imm,
   input  logic [NUM_FWD-1:0]                fwd_valid,
   input  logic [NUM_FWD*REG_ADDR_WIDTH-1:0] fwd_rd,
   input  logic [NUM_FWD*REG_WIDTH-1:0]      fwd_data,
   input  logic                              wb_en,
   input  logic [REG_ADDR_WIDTH-1:0]         wb_rd,
   input  logic [REG_WIDTH-1:0]              wb_data,
   input  logic                              ex_ready,
   output logic                              ex_valid,
   output logic [PC_WIDTH-1:0]               ex_pc,
   output logic [REG_WIDTH-1:0]              ex_rs1_data,
   output logic [REG_WIDTH-1:0]              ex_rs2_data,
   output logic [REG_WIDTH-1:0]              ex_imm,
   output logic [REG_ADDR_WIDTH-1:0]         ex_rd,
   output logic                              ex_rd_wr,
   output logic                              ex_is_load,
   output logic                              pc_sel,
   output logic [PC_WIDTH-1:0]               pc_target,
   output logic                              IF_flush,
   output logic [CNT_WIDTH-1:0]              stall_cnt,
   output logic                              stall_state
);

   // Handshake: an instruction moves from ID into the ID/EX register on a clock
   // where id_valid & id_ready; ID/EX contents are consumed where ex_valid & ex_ready,
   // and are held unchanged while ex_valid & !ex_ready.

   typedef enum logic {RUN = 1'b0, STALL = 1'b1} stall_fsm_t;
   stall_fsm_t state, state_nxt;

   logic [REG_WIDTH-1:0] regs [NUM_REG];
   logic [REG_WIDTH-1:0] rs1_val, rs2_val;
   logic                 hazard, transfer, ex_load_en, lt, taken;

   // Youngest forward source wins, then write-through, then the array; x0 is always 0.
   function automatic logic [REG_WIDTH-1:0] pick_operand(
      input logic [REG_ADDR_WIDTH-1:0]         idx,
      input logic [REG_WIDTH-1:0]              rf_val,
      input logic [NUM_FWD-1:0]                fv,
      input logic [NUM_FWD*REG_ADDR_WIDTH-1:0] fr,
      input logic [NUM_FWD*REG_WIDTH-1:0]      fd,
      input logic                              we,
      input logic [REG_ADDR_WIDTH-1:0]         wr,
      input logic [REG_WIDTH-1:0]              wd
   );
      logic [REG_WIDTH-1:0] val;
      val = (we && wr == idx) ? wd : rf_val;
      for (int i = NUM_FWD - 1; i >= 0; i--) begin
         if (fv[i] && fr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == idx)
            val = fd[i*REG_WIDTH +: REG_WIDTH];
      end
      if (idx == '0)
         val = '0;
      return val;
   endfunction

   always_comb begin
      rs1_val = pick_operand(id_rs1, regs[id_rs1], fwd_valid, fwd_rd, fwd_data,
                             wb_en, wb_rd, wb_data);
      rs2_val = pick_operand(id_rs2, regs[id_rs2], fwd_valid, fwd_rd, fwd_data,
                             wb_en, wb_rd, wb_data);
   end

   assign hazard     = ex_valid && ex_is_load && (ex_rd != '0) && id_valid &&
                       ((ex_rd == id_rs1) || (ex_rd == id_rs2));
   assign ex_load_en = !ex_valid || ex_ready;
   assign id_ready   = !hazard && ex_load_en;
   assign transfer   = id_valid && id_ready;

   always_comb begin
      lt    = id_br_un ? (rs1_val < rs2_val) : ($signed(rs1_val) < $signed(rs2_val));
      taken = 1'b0;
      case (id_br_type)
         2'b00:   taken = (rs1_val == rs2_val);
         2'b01:   taken = (rs1_val != rs2_val);
         2'b10:   taken = lt;
         default: taken = !lt;
      endcase
   end

   assign pc_sel    = reset_n && transfer && id_is_branch && taken;
   assign IF_flush  = pc_sel;
   assign pc_target = id_pc + PC_WIDTH'($signed(id_imm));

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_REG; i++)
            regs[i] <= '0;
      end else if (wb_en && wb_rd != '0) begin
         regs[wb_rd] <= wb_data;
      end
   end

   // A bubble only clears ex_valid; stale data fields are never observed.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ex_valid    <= 1'b0;
         ex_pc       <= '0;
         ex_rs1_data <= '0;
         ex_rs2_data <= '0;
         ex_imm      <= '0;
         ex_rd       <= '0;
         ex_rd_wr    <= 1'b0;
         ex_is_load  <= 1'b0;
      end else if (ex_load_en) begin
         ex_valid <= transfer;
         if (transfer) begin
            ex_pc       <= id_pc;
            ex_rs1_data <= rs1_val;
            ex_rs2_data <= rs2_val;
            ex_imm      <= id_imm;
            ex_rd       <= id_rd;
            ex_rd_wr    <= id_rd_wr;
            ex_is_load  <= id_is_load;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n)
         state <= RUN;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (id_valid && !id_ready) state_nxt = STALL;
         STALL:   if (!id_valid || id_ready) state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   assign stall_state = (state == STALL);

   always_ff @(posedge clk) begin
      if (!reset_n)
         stall_cnt <= '0;
      else if (id_valid && !id_ready && stall_cnt != '1)
         stall_cnt <= stall_cnt + CNT_WIDTH'(1);
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a transaction-level model predicts every
// accepted instruction and the combinational branch/handshake outputs.
module tb_id_ex_stage;

   localparam int AW    = 5;
   localparam int RW    = 32;
   localparam int PW    = 32;
   localparam int NF    = 3;
   localparam int EXP_W = PW + 3*RW + AW + 2;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              id_valid, id_rd_wr, id_is_load, id_is_branch, id_br_un;
   logic              id_ready;
   logic [PW-1:0]     id_pc;
   logic [AW-1:0]     id_rs1, id_rs2, id_rd;
   logic [1:0]        id_br_type;
   logic [RW-1:0]     id_imm;
   logic [NF-1:0]     fwd_valid;
   logic [NF*AW-1:0]  fwd_rd;
   logic [NF*RW-1:0]  fwd_data;
   logic              wb_en;
   logic [AW-1:0]     wb_rd;
   logic [RW-1:0]     wb_data;
   logic              ex_ready;
   logic              ex_valid, ex_rd_wr, ex_is_load, pc_sel, IF_flush, stall_state;
   logic [PW-1:0]     ex_pc, pc_target;
   logic [RW-1:0]     ex_rs1_data, ex_rs2_data, ex_imm;
   logic [AW-1:0]     ex_rd;
   logic [15:0]       stall_cnt;

   // second instance with a 2-bit stall counter, sharing all inputs
   logic              s_id_ready, s_ex_valid, s_ex_rd_wr, s_ex_is_load, s_pc_sel, s_IF_flush, s_stall_state;
   logic [PW-1:0]     s_ex_pc, s_pc_target;
   logic [RW-1:0]     s_ex_rs1_data, s_ex_rs2_data, s_ex_imm;
   logic [AW-1:0]     s_ex_rd;
   logic [1:0]        s_stall_cnt;

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_ready(id_ready),
      .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_rd_wr(id_rd_wr), .id_is_load(id_is_load), .id_is_branch(id_is_branch),
      .id_br_un(id_br_un), .id_br_type(id_br_type), .id_imm(id_imm),
      .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
      .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .ex_ready(ex_ready),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
      .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rd(ex_rd),
      .ex_rd_wr(ex_rd_wr), .ex_is_load(ex_is_load), .pc_sel(pc_sel),
      .pc_target(pc_target), .IF_flush(IF_flush), .stall_cnt(stall_cnt),
      .stall_state(stall_state)
   );

   id_ex_stage #(.CNT_WIDTH(2)) dut_sat (
      .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_ready(s_id_ready),
      .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_rd_wr(id_rd_wr), .id_is_load(id_is_load), .id_is_branch(id_is_branch),
      .id_br_un(id_br_un), .id_br_type(id_br_type), .id_imm(id_imm),
      .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
      .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .ex_ready(ex_ready),
      .ex_valid(s_ex_valid), .ex_pc(s_ex_pc), .ex_rs1_data(s_ex_rs1_data),
      .ex_rs2_data(s_ex_rs2_data), .ex_imm(s_ex_imm), .ex_rd(s_ex_rd),
      .ex_rd_wr(s_ex_rd_wr), .ex_is_load(s_ex_is_load), .pc_sel(s_pc_sel),
      .pc_target(s_pc_target), .IF_flush(s_IF_flush), .stall_cnt(s_stall_cnt),
      .stall_state(s_stall_state)
   );

   // ---------------- scoreboard and model state ----------------
   logic [EXP_W-1:0] exp_q[$];
   int               n_checks = 0;
   int               n_pass   = 0;
   bit               mon_en   = 1'b0;

   logic [RW-1:0]    m_rf [32];
   bit               m_ex_valid = 1'b0, m_ex_is_load = 1'b0, m_stalled = 1'b0;
   logic [AW-1:0]    m_ex_rd = '0;
   int               m_stall_cnt = 0, m_sat_cnt = 0;

   bit               exp_id_ready = 1'b0, exp_pc_sel = 1'b0;
   logic [PW-1:0]    exp_pc_target = '0;

   bit               n_rst, n_wb, n_upd, n_xfer, n_load, n_stall;
   logic [AW-1:0]    n_wb_rd, n_rd;
   logic [RW-1:0]    n_wb_data;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
   endtask

   task automatic check_rec(input logic [EXP_W-1:0] act, input logic [EXP_W-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL ex_record at %0t: got 0x%0h expected 0x%0h", $time, act, exp);
   endtask

   // Operand value as an instruction in ID should see it.
   function automatic logic [RW-1:0] operand(input logic [AW-1:0] idx);
      if (idx == 0) return '0;
      for (int i = 0; i < NF; i++)
         if (fwd_valid[i] && fwd_rd[i*AW +: AW] == idx) return fwd_data[i*RW +: RW];
      if (wb_en && wb_rd == idx) return wb_data;
      return m_rf[idx];
   endfunction

   task automatic eval_model();
      bit hz, xfer, lt, taken;
      logic [RW-1:0] a, b;
      hz = m_ex_valid && m_ex_is_load && m_ex_rd != 0 && id_valid &&
           (m_ex_rd == id_rs1 || m_ex_rd == id_rs2);
      exp_id_ready = !hz && (!m_ex_valid || ex_ready);
      xfer = id_valid && exp_id_ready;
      a = operand(id_rs1);
      b = operand(id_rs2);
      lt = id_br_un ? (a < b) : ($signed(a) < $signed(b));
      case (id_br_type)
         2'd0:    taken = (a == b);
         2'd1:    taken = (a != b);
         2'd2:    taken = lt;
         default: taken = !lt;
      endcase
      exp_pc_sel    = reset_n && xfer && id_is_branch && taken;
      exp_pc_target = id_pc + id_imm;
      n_rst     = !reset_n;
      n_wb      = wb_en && wb_rd != 0;
      n_wb_rd   = wb_rd;
      n_wb_data = wb_data;
      n_upd     = !m_ex_valid || ex_ready;
      n_xfer    = xfer;
      n_load    = id_is_load;
      n_rd      = id_rd;
      n_stall   = id_valid && !exp_id_ready;
      if (reset_n && n_upd && xfer)
         exp_q.push_back({id_pc, a, b, id_imm, id_rd, id_rd_wr, id_is_load});
   endtask

   task automatic commit_model();
      if (n_rst) begin
         for (int i = 0; i < 32; i++) m_rf[i] = '0;
         m_ex_valid = 1'b0; m_ex_is_load = 1'b0; m_ex_rd = '0;
         m_stall_cnt = 0; m_sat_cnt = 0; m_stalled = 1'b0;
         exp_q.delete();
      end else begin
         if (n_wb) m_rf[n_wb_rd] = n_wb_data;
         if (n_upd) begin
            m_ex_valid = n_xfer;
            if (n_xfer) begin m_ex_is_load = n_load; m_ex_rd = n_rd; end
         end
         if (n_stall) begin
            if (m_stall_cnt < 65535) m_stall_cnt++;
            if (m_sat_cnt < 3) m_sat_cnt++;
         end
         m_stalled = n_stall;
      end
   endtask

   // Inputs are set at posedge+1; this predicts, crosses the edge and commits.
   task automatic step();
      eval_model();
      @(posedge clk);
      commit_model();
      #1;
   endtask

   // ---------------- monitor ----------------
   initial begin
      forever begin
         @(negedge clk);
         if (mon_en) begin
            check("id_ready", id_ready, exp_id_ready);
            check("pc_sel", pc_sel, exp_pc_sel);
            check("IF_flush", IF_flush, exp_pc_sel);
            check("pc_target", pc_target, exp_pc_target);
            check("ex_valid", ex_valid, m_ex_valid);
            check("stall_cnt", stall_cnt, m_stall_cnt);
            check("sat_stall_cnt", s_stall_cnt, m_sat_cnt);
            check("stall_state", stall_state, m_stalled);
            if (ex_valid && ex_ready) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  $display("FAIL ex_record at %0t: got valid output, expected queue empty", $time);
               end else begin
                  check_rec({ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rd, ex_rd_wr, ex_is_load},
                            exp_q.pop_front());
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic idle();
      reset_n = 1'b1; id_valid = 1'b0; id_pc = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
      id_rd_wr = 1'b0; id_is_load = 1'b0; id_is_branch = 1'b0; id_br_un = 1'b0;
      id_br_type = 2'd0; id_imm = '0; fwd_valid = '0; fwd_rd = '0; fwd_data = '0;
      wb_en = 1'b0; wb_rd = '0; wb_data = '0; ex_ready = 1'b1;
   endtask

   task automatic set_fwd(input int i, input logic [AW-1:0] rd, input logic [RW-1:0] data);
      fwd_rd[i*AW +: AW]   = rd;
      fwd_data[i*RW +: RW] = data;
   endtask

   function automatic logic [RW-1:0] pick_data();
      case ($urandom_range(0, 4))
         0:       return 32'h0000_0001;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h0000_0000;
         default: return $urandom;
      endcase
   endfunction

   task automatic rand_inputs();
      reset_n      = ($urandom_range(0, 299) != 0);
      id_valid     = ($urandom_range(0, 9) < 8);
      id_pc        = $urandom;
      id_rs1       = AW'($urandom_range(0, 7));
      id_rs2       = AW'($urandom_range(0, 7));
      id_rd        = AW'($urandom_range(0, 7));
      id_rd_wr     = 1'($urandom_range(0, 1));
      id_is_load   = ($urandom_range(0, 9) < 3);
      id_is_branch = ($urandom_range(0, 9) < 4);
      id_br_un     = 1'($urandom_range(0, 1));
      id_br_type   = 2'($urandom_range(0, 3));
      id_imm       = $urandom;
      fwd_valid    = NF'($urandom_range(0, 7));
      for (int i = 0; i < NF; i++) set_fwd(i, AW'($urandom_range(0, 7)), pick_data());
      wb_en        = 1'($urandom_range(0, 1));
      wb_rd        = AW'($urandom_range(0, 7));
      wb_data      = pick_data();
      ex_ready     = ($urandom_range(0, 3) != 0);
   endtask

   // ---------------- directed + random sequence ----------------
   int saved_cnt;

   initial begin
      idle();
      reset_n = 1'b0;
      id_valid = 1'b1; id_is_branch = 1'b1;   // BEQ x0,x0 would be taken outside reset
      #1;
      step();
      mon_en = 1'b1;
      step();
      check("rst_ex_valid", ex_valid, 0);
      check("rst_ex_pc", ex_pc, 0);
      check("rst_ex_rs1", ex_rs1_data, 0);
      check("rst_stall_cnt", stall_cnt, 0);

      // write-through of a same-cycle writeback
      idle();
      wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF; id_valid = 1'b1; id_rs1 = 5'd5;
      step();
      check("wt_ex_valid", ex_valid, 1);
      check("wt_ex_rs1", ex_rs1_data, 32'hDEADBEEF);

      // forward priority and x0
      idle();
      id_valid = 1'b1; fwd_valid = 3'b111; id_rs2 = 5'd7;
      set_fwd(0, 5'd7, 32'h11); set_fwd(1, 5'd7, 32'h22); set_fwd(2, 5'd7, 32'h33);
      step();
      check("fwd_prio_rs2", ex_rs2_data, 32'h11);
      id_rs2 = 5'd0;
      step();
      check("fwd_x0_rs2", ex_rs2_data, 0);

      // load-use: one bubble then accept
      idle();
      id_valid = 1'b1; id_is_load = 1'b1; id_rd = 5'd3; id_rd_wr = 1'b1;
      step();
      id_is_load = 1'b0; id_rd = 5'd4; id_rs1 = 5'd3;
      saved_cnt = m_stall_cnt;
      #1 check("lu_id_ready_c0", id_ready, 0);
      step();
      check("lu_stall_cnt", stall_cnt, 16'(saved_cnt + 1));
      check("lu_bubble", ex_valid, 0);
      #1 check("lu_id_ready_c1", id_ready, 1);
      step();
      check("lu_accept_valid", ex_valid, 1);
      check("lu_accept_rd", ex_rd, 4);

      // BLT -1 < 1 signed taken, unsigned not taken
      idle();
      id_valid = 1'b1; id_is_branch = 1'b1; id_br_type = 2'd2; id_rs1 = 5'd1; id_rs2 = 5'd2;
      fwd_valid = 3'b011; set_fwd(0, 5'd1, 32'hFFFF_FFFF); set_fwd(1, 5'd2, 32'h1);
      id_pc = 32'h1000; id_imm = 32'h20;
      #1;
      check("blt_pc_sel", pc_sel, 1);
      check("blt_if_flush", IF_flush, 1);
      check("blt_target", pc_target, 32'h1020);
      step();
      id_br_un = 1'b1;
      #1 check("bltu_pc_sel", pc_sel, 0);
      step();

      // backpressure holds the register and counts stalls
      idle();
      id_valid = 1'b1; id_pc = 32'h2000; id_rd = 5'd9; id_rd_wr = 1'b1; id_imm = 32'h55;
      step();
      id_pc = 32'h3000; id_rd = 5'd10; ex_ready = 1'b0;
      saved_cnt = m_stall_cnt;
      for (int k = 0; k < 4; k++) begin
         step();
         check("bp_ex_pc", ex_pc, 32'h2000);
         check("bp_ex_rd", ex_rd, 9);
      end
      check("bp_stall_cnt", stall_cnt, 16'(saved_cnt + 4));
      check("sat_hold", s_stall_cnt, 3);
      reset_n = 1'b0;
      step();
      check("rst2_ex_valid", ex_valid, 0);
      check("rst2_stall_cnt", stall_cnt, 0);
      check("rst2_sat_cnt", s_stall_cnt, 0);
      idle();
      step();

      // randomized traffic
      for (int k = 0; k < 3000; k++) begin
         rand_inputs();
         step();
      end

      idle();
      for (int k = 0; k < 4; k++) step();
      check("drain_queue", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
